// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Program loader sitting in front of the instruction memory. Decoded
// instruction fields arrive over a valid/ready stream, get packed into 32-bit
// RISC-V words and are written to consecutive word addresses starting at 0.
// Supported classes: R-type ALU, I-type ALU, BEQ, JAL, LW and SW.
//
// Ports
//   clk        system clock, rising-edge
//   arst       asynchronous active-high reset
//   start      one-cycle pulse starting a new load (IDLE/DONE/ERR only)
//   in_valid   instruction fields valid
//   in_ready   encoder can take fields (ACCEPT only)
//   in_class   0 R, 1 I-ALU, 2 BEQ, 3 JAL, 4 LW, 5 SW; 6/7 illegal
//   in_funct   {funct7[5], funct3}, R and I-ALU only
//   in_rd/in_rs1/in_rs2  register indices
//   in_imm     21-bit two's complement immediate
//   in_last    final instruction of the program
//   mem_we     instruction-memory write strobe (one cycle per word)
//   mem_addr   write word address
//   mem_wdata  encoded instruction word
//   busy       high in ACCEPT and WRITE
//   done       high in DONE (held until start/reset)
//   err        high in ERR (held until start/reset)
//   count      words written since the last start (saturates at DEPTH)
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [3:0]        in_funct,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  // Highest word address and the saturation value of count (DEPTH).
  localparam logic [ADDR_W-1:0] PTR_LAST   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  // Instruction classes as presented on in_class.
  localparam logic [2:0] CLS_R   = 3'd0;
  localparam logic [2:0] CLS_I   = 3'd1;
  localparam logic [2:0] CLS_BEQ = 3'd2;
  localparam logic [2:0] CLS_JAL = 3'd3;
  localparam logic [2:0] CLS_LW  = 3'd4;
  localparam logic [2:0] CLS_SW  = 3'd5;

  // RISC-V major opcodes and fixed funct3 values.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic                last_reg;

  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                xfer;
  logic                start_ok;

  // A transfer can only happen in ACCEPT, where in_ready is high.
  assign xfer     = (state_reg == S_ACCEPT) && in_valid;
  assign start_ok = start && ((state_reg == S_IDLE) ||
                              (state_reg == S_DONE) ||
                              (state_reg == S_ERR));

  // -------------------------------------------------------------------------
  // Field packing. Fields a class does not use never reach the word; the
  // branch and jump offsets are halfword-aligned so imm[0] is dropped.
  // -------------------------------------------------------------------------
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_class)
      CLS_R:   enc_word = {1'b0, in_funct[3], 5'b00000, in_rs2, in_rs1,
                           in_funct[2:0], in_rd, OP_R};
      CLS_I:   enc_word = {in_imm[11:0], in_rs1, in_funct[2:0], in_rd, OP_I};
      CLS_LW:  enc_word = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OP_LOAD};
      CLS_SW:  enc_word = {in_imm[11:5], in_rs2, in_rs1, F3_WORD,
                           in_imm[4:0], OP_STORE};
      CLS_BEQ: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ,
                           in_imm[4:1], in_imm[11], OP_BRANCH};
      CLS_JAL: enc_word = {in_imm[20], in_imm[10:1], in_imm[11],
                           in_imm[19:12], in_rd, OP_JAL};
      default: enc_legal = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (xfer) begin
          state_next = enc_legal ? S_WRITE : S_ERR;
        end
      end
      S_WRITE: begin
        // last wins over overflow: a program that exactly fills memory
        // is a legal full program.
        if (last_reg) begin
          state_next = S_DONE;
        end else if (ptr_reg == PTR_LAST) begin
          state_next = S_ERR;
        end else begin
          state_next = S_ACCEPT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      count_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start_ok) begin
        ptr_reg   <= '0;
        count_reg <= '0;
      end

      // Capture the word together with the address it will land at, so
      // mem_addr/mem_wdata stay put after the pointer moves on.
      if (xfer && enc_legal) begin
        addr_reg  <= ptr_reg;
        wdata_reg <= enc_word;
        last_reg  <= in_last;
      end

      if (state_reg == S_WRITE) begin
        ptr_reg <= ptr_reg + 1'b1;
        if (count_reg != COUNT_FULL) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. mem_we decodes straight from the state register so an
  // asynchronous reset drops it in the same cycle.
  // -------------------------------------------------------------------------
  assign in_ready  = (state_reg == S_ACCEPT);
  assign mem_we    = (state_reg == S_WRITE);
  assign busy      = (state_reg == S_ACCEPT) || (state_reg == S_WRITE);
  assign done      = (state_reg == S_DONE);
  assign err       = (state_reg == S_ERR);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. Programs of directed and random
// instructions are streamed in; every write is compared against a reference
// encoder that builds words from the RISC-V field rules with shifts and
// masks, and the loader's status (done/err/count/in_ready) is tracked by a
// simple program-level model.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_class = '0;
  logic [3:0]    in_funct = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [20:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .arst      (arst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct  (in_funct),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  typedef struct {
    int          cls;
    int          f;
    int          rd;
    int          rs1;
    int          rs2;
    logic [20:0] imm;
    bit          last;
    logic [31:0] lit;   // known-good word from hand assembly, 0 = none
  } instr_t;

  int     n_vec = 0;
  int     n_err = 0;
  int     exp_ptr;
  int     exp_count;
  instr_t prog_q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: assembles the word from the architectural field
  // positions using integer shifts and masks.
  function automatic logic [31:0] ref_enc(input instr_t t);
    int imm;
    int w;
    imm = int'(t.imm);
    w = 0;
    case (t.cls)
      0: w = (((t.f >> 3) & 1) << 30) | (t.rs2 << 20) | (t.rs1 << 15) |
             ((t.f & 7) << 12) | (t.rd << 7) | 'h33;
      1: w = ((imm & 'hFFF) << 20) | (t.rs1 << 15) | ((t.f & 7) << 12) |
             (t.rd << 7) | 'h13;
      2: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
             (t.rs2 << 20) | (t.rs1 << 15) | (((imm >> 1) & 15) << 8) |
             (((imm >> 11) & 1) << 7) | 'h63;
      3: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) |
             (t.rd << 7) | 'h6F;
      4: w = ((imm & 'hFFF) << 20) | (t.rs1 << 15) | (2 << 12) |
             (t.rd << 7) | 'h03;
      5: w = (((imm >> 5) & 127) << 25) | (t.rs2 << 20) | (t.rs1 << 15) |
             (2 << 12) | ((imm & 31) << 7) | 'h23;
      default: w = 0;
    endcase
    return 32'(w);
  endfunction

  function automatic instr_t mk(input int cls, input int f, input int rd,
                                input int rs1, input int rs2,
                                input logic [20:0] imm, input bit last,
                                input logic [31:0] lit);
    instr_t t;
    t.cls = cls; t.f = f; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.imm = imm; t.last = last; t.lit = lit;
    return t;
  endfunction

  // Random legal instruction; unused fields are random too.
  function automatic instr_t rand_instr(input bit last);
    return mk($urandom_range(0, 5), $urandom_range(0, 15),
              $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), 21'($urandom), last, 32'h0);
  endfunction

  task automatic drive(input instr_t t);
    in_class = 3'(t.cls);
    in_funct = 4'(t.f);
    in_rd    = 5'(t.rd);
    in_rs1   = 5'(t.rs1);
    in_rs2   = 5'(t.rs2);
    in_imm   = t.imm;
    in_last  = t.last;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_ptr   = 0;
    exp_count = 0;
    check("start_busy",  busy,     1);
    check("start_ready", in_ready, 1);
    check("start_count", count,    0);
    check("start_done",  done,     0);
    check("start_err",   err,      0);
  endtask

  // One instruction through the handshake, its write cycle, and the status
  // that follows. stop=1 when the loader left ACCEPT for good.
  task automatic send(input instr_t t, output bit stop);
    int waited;
    logic [31:0] exp_word;
    stop = 1'b0;
    if (!in_valid) repeat ($urandom_range(0, 2)) tick();
    drive(t);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      stop = 1'b1;
      return;
    end
    tick();                     // transfer edge
    in_valid = 1'b0;
    in_imm   = 21'($urandom);   // fields are free to change after transfer
    if (t.cls >= 6) begin
      check("illegal_we",    mem_we, 0);
      check("illegal_err",   err,    1);
      check("illegal_count", count,  exp_count);
      stop = 1'b1;
      return;
    end
    exp_word = (t.lit != 0) ? t.lit : ref_enc(t);
    check("wr_we",    mem_we,    1);
    check("wr_addr",  mem_addr,  exp_ptr);
    check("wr_data",  mem_wdata, exp_word);
    check("wr_ready", in_ready,  0);
    check("wr_count", count,     exp_count);
    $display("write addr=%0d data=0x%08h class=%0d last=%0d",
             mem_addr, mem_wdata, t.cls, t.last);
    exp_ptr++;
    exp_count++;
    tick();
    check("post_we",    mem_we,   0);
    check("post_addr",  mem_addr, exp_ptr - 1);
    check("post_count", count,    exp_count);
    if (t.last) begin
      check("post_done", done, 1);
      stop = 1'b1;
    end else if (exp_count == DEPTH) begin
      check("post_ovf_err", err, 1);
      stop = 1'b1;
    end else begin
      check("post_ready", in_ready, 1);
    end
  endtask

  // Runs prog_q as a program; the first instruction is presented before
  // start so in_valid leads in_ready.
  task automatic run_prog();
    bit stop;
    if (prog_q.size() == 0) return;
    drive(prog_q[0]);
    in_valid = 1'b1;
    check("ready_before_start", in_ready, 0);
    do_start();
    foreach (prog_q[i]) begin
      send(prog_q[i], stop);
      if (stop) break;
    end
    prog_q.delete();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stop;
    int len;

    // Reset
    #2 arst = 1'b1;
    tick();
    check("rst_ready", in_ready,  0);
    check("rst_we",    mem_we,    0);
    check("rst_addr",  mem_addr,  0);
    check("rst_data",  mem_wdata, 0);
    check("rst_busy",  busy,      0);
    check("rst_done",  done,      0);
    check("rst_err",   err,       0);
    check("rst_count", count,     0);
    arst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // add x3,x1,x2
    prog_q.push_back(mk(0, 0, 3, 1, 2, 21'h0, 1, 32'h002081B3));
    run_prog();
    check("add_count", count, 1);

    // sub x3,x1,x2 ; lw x5,8(x2)
    prog_q.push_back(mk(0, 8, 3, 1, 2, 21'h0, 0, 32'h402081B3));
    prog_q.push_back(mk(4, 0, 5, 2, 0, 21'd8, 1, 32'h00812283));
    run_prog();
    check("sublw_count", count, 2);

    // beq x1,x2,-8 ; jal x1,16
    prog_q.push_back(mk(2, 0, 0, 1, 2, 21'h1FFFF8, 0, 32'hFE208CE3));
    prog_q.push_back(mk(3, 0, 1, 0, 0, 21'd16, 1, 32'h010000EF));
    run_prog();

    // Illegal class at the start, then after one legal write
    prog_q.push_back(mk(6, 0, 1, 1, 1, 21'h0, 0, 32'h0));
    run_prog();
    prog_q.push_back(rand_instr(0));
    prog_q.push_back(mk(7, 3, 2, 2, 2, 21'h5, 1, 32'h0));
    run_prog();
    check("illegal7_count", count, 1);

    // start in ACCEPT is ignored: pointer and count keep going
    do_start();
    send(rand_instr(0), stop);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start_count", count,    1);
    check("ign_start_ready", in_ready, 1);
    send(rand_instr(1), stop);
    check("ign_start_final", count, 2);

    // Random programs of random length
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) prog_q.push_back(rand_instr(i == len - 1));
      run_prog();
    end

    // Exactly full legal program
    for (int i = 0; i < DEPTH; i++) prog_q.push_back(rand_instr(i == DEPTH - 1));
    run_prog();
    check("full_done",  done,  1);
    check("full_count", count, DEPTH);

    // Overflow: DEPTH words without last
    for (int i = 0; i < DEPTH; i++) prog_q.push_back(rand_instr(0));
    run_prog();
    check("ovf_err",   err,   1);
    check("ovf_count", count, DEPTH);
    drive(rand_instr(0));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf_ready", in_ready, 0);
      check("ovf_we",    mem_we,   0);
    end
    in_valid = 1'b0;

    // Reset asserted during a WRITE cycle
    do_start();
    drive(mk(3, 0, 7, 0, 0, 21'h0ABCD, 0, 32'h0));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rstw_we_before", mem_we, 1);
    #2 arst = 1'b1;
    #1;
    check("rstw_we",   mem_we,    0);
    check("rstw_busy", busy,      0);
    check("rstw_data", mem_wdata, 0);
    tick();
    arst = 1'b0;
    tick();
    check("rstw_ready", in_ready,  0);
    check("rstw_addr",  mem_addr,  0);
    check("rstw_wdata", mem_wdata, 0);
    check("rstw_done",  done,      0);
    check("rstw_err",   err,       0);
    check("rstw_count", count,     0);
    check("rstw_idle",  busy,      0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
